// File: rtl/alu_unit_if.sv
// alu_unit_if: issue bus from the reservation station and result bus toward the CDB.
interface alu_unit_if #(
    parameter int DAT_W   = 32,
    parameter int ROB_BIT = 4,
    parameter int OP_W    = 6
);
    logic               alu_en_i;
    logic [OP_W-1:0]    alu_op_i;
    logic               alu_ic_i;
    logic [ROB_BIT-1:0] alu_qd_i;
    logic [DAT_W-1:0]   alu_vs_i;
    logic [DAT_W-1:0]   alu_vt_i;
    logic [DAT_W-1:0]   alu_imm_i;
    logic [DAT_W-1:0]   alu_pc_i;
    logic               alu_rdy_o;
    logic               cdb_en_o;
    logic [ROB_BIT-1:0] cdb_q_o;
    logic [DAT_W-1:0]   cdb_v_o;
    logic               cdb_br_o;
    logic               cdb_taken_o;
    logic [DAT_W-1:0]   cdb_tgt_o;
    logic               cdb_gnt_i;
    logic               ovf_o;
    logic               br_flag;
    modport slave (
        input  alu_en_i, alu_op_i, alu_ic_i, alu_qd_i, alu_vs_i, alu_vt_i, alu_imm_i, alu_pc_i,
        input  cdb_gnt_i, br_flag,
        output alu_rdy_o, cdb_en_o, cdb_q_o, cdb_v_o, cdb_br_o, cdb_taken_o, cdb_tgt_o, ovf_o
    );
    modport master (
        output alu_en_i, alu_op_i, alu_ic_i, alu_qd_i, alu_vs_i, alu_vt_i, alu_imm_i, alu_pc_i,
        output cdb_gnt_i, br_flag,
        input  alu_rdy_o, cdb_en_o, cdb_q_o, cdb_v_o, cdb_br_o, cdb_taken_o, cdb_tgt_o, ovf_o
    );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: one-stage integer/branch execute unit feeding a small result FIFO toward the CDB.
module alu_unit #(
    parameter int DAT_W   = 32,
    parameter int ROB_BIT = 4,
    parameter int OP_W    = 6,
    parameter int FIFO_D  = 4
) (
    input logic       clk,
    input logic       rst,
    alu_unit_if.slave bus
);
    localparam int PW = $clog2(FIFO_D);
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic               ic;
        logic [ROB_BIT-1:0] qd;
        logic [DAT_W-1:0]   vs, vt, imm, pc;
    } s1_t;
    typedef struct packed {
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
        logic               br, taken;
        logic [DAT_W-1:0]   tgt;
    } ent_t;
    s1_t s1_q, s1_d;
    ent_t mem_q [FIFO_D];
    ent_t mem_d [FIFO_D];
    ent_t res, head;
    logic s1_vld_q, s1_vld_d, ovf_q, ovf_d, rdy, push, pop, eq, lt, ltu;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic [DAT_W-1:0] b, nxt;
    logic [4:0] sh, cls;
    always_comb begin
        cls = s1_q.op[4:0];
        b = s1_q.op[5] ? s1_q.imm : s1_q.vt;
        sh = b[4:0];
        nxt = s1_q.pc + (s1_q.ic ? DAT_W'(2) : DAT_W'(4));
        eq = s1_q.vs == s1_q.vt;
        lt = $signed(s1_q.vs) < $signed(s1_q.vt);
        ltu = s1_q.vs < s1_q.vt;
        res = '0;
        res.q = s1_q.qd;
        case (cls)
            5'd0:  res.v = s1_q.vs + b;
            5'd1:  res.v = s1_q.vs - b;
            5'd2:  res.v = s1_q.vs << sh;
            5'd3:  res.v = DAT_W'($signed(s1_q.vs) < $signed(b));
            5'd4:  res.v = DAT_W'(s1_q.vs < b);
            5'd5:  res.v = s1_q.vs ^ b;
            5'd6:  res.v = s1_q.vs >> sh;
            5'd7:  res.v = $signed(s1_q.vs) >>> sh;
            5'd8:  res.v = s1_q.vs | b;
            5'd9:  res.v = s1_q.vs & b;
            5'd10: res.v = s1_q.imm;
            5'd11: res.v = s1_q.pc + s1_q.imm;
            5'd12, 5'd13: {res.v, res.br, res.taken} = {nxt, 2'b11};
            5'd14: {res.br, res.taken} = {1'b1, eq};
            5'd15: {res.br, res.taken} = {1'b1, !eq};
            5'd16: {res.br, res.taken} = {1'b1, lt};
            5'd17: {res.br, res.taken} = {1'b1, !lt};
            5'd18: {res.br, res.taken} = {1'b1, ltu};
            5'd19: {res.br, res.taken} = {1'b1, !ltu};
            default: ;
        endcase
        res.tgt = !res.taken ? nxt :
                  (cls == 5'd13) ? (s1_q.vs + s1_q.imm) & ~DAT_W'(1) : s1_q.pc + s1_q.imm;
    end
    // Occupancy counts the op sitting in S1, so an accepted op always finds a FIFO slot.
    always_comb begin
        rdy = ({1'b0, cnt_q} + (PW+2)'(s1_vld_q)) < (PW+2)'(FIFO_D);
        push = s1_vld_q & ~bus.br_flag;
        pop = (cnt_q != '0) & bus.cdb_gnt_i & ~bus.br_flag;
        s1_vld_d = bus.alu_en_i & rdy & ~bus.br_flag;
        s1_d = (bus.alu_en_i & rdy) ? {bus.alu_op_i, bus.alu_ic_i, bus.alu_qd_i, bus.alu_vs_i,
                                       bus.alu_vt_i, bus.alu_imm_i, bus.alu_pc_i} : s1_q;
        ovf_d = bus.alu_en_i & ~rdy;
        wr_d = bus.br_flag ? '0 : wr_q + PW'(push);
        rd_d = bus.br_flag ? '0 : rd_q + PW'(pop);
        cnt_d = bus.br_flag ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        mem_d = mem_q;
        if (push) mem_d[wr_q] = res;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_q <= '0;
            ovf_q <= 1'b0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q <= s1_d;
            ovf_q <= ovf_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    // Head fields are masked while empty so stale entries never reach the CDB.
    assign head = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign bus.alu_rdy_o = rdy;
    assign bus.cdb_en_o = cnt_q != '0;
    assign bus.cdb_q_o = head.q;
    assign bus.cdb_v_o = head.v;
    assign bus.cdb_br_o = head.br;
    assign bus.cdb_taken_o = head.taken;
    assign bus.cdb_tgt_o = head.tgt;
    assign bus.ovf_o = ovf_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: table vectors, directed corner sequences and random traffic against a queue model.
module tb_alu_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    alu_unit_if #(.DAT_W(32), .ROB_BIT(4), .OP_W(6)) bus ();
    alu_unit #(.DAT_W(32), .ROB_BIT(4), .OP_W(6), .FIFO_D(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [31:0] v;
        logic        br, taken;
        logic [31:0] tgt;
    } res_t;
    typedef struct {
        logic [3:0] q;
        res_t       r;
        int         t_vis;
    } sb_t;
    typedef struct {
        logic [5:0]  op;
        logic        ic;
        logic [31:0] vs, vt, imm, pc;
        res_t        r;
    } vec_t;
    sb_t  sbq[$];
    vec_t tab[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic exp_ovf = 1'b0;
    res_t cur_exp;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    function automatic res_t model(logic [5:0] op, logic ic, logic [31:0] vs, vt, imm, pc);
        res_t r;
        logic [31:0] b, nxt;
        int sh, sv, st, sb;
        b = op[5] ? imm : vt;
        sh = int'(b[4:0]);
        nxt = pc + (ic ? 32'd2 : 32'd4);
        sv = vs;
        st = vt;
        sb = b;
        r = '{32'd0, 1'b0, 1'b0, nxt};
        case (op[4:0])
            5'd0:  r.v = vs + b;
            5'd1:  r.v = vs - b;
            5'd2:  r.v = 32'(64'(vs) * (64'd1 << sh));
            5'd3:  r.v = {31'd0, sv < sb};
            5'd4:  r.v = {31'd0, vs < b};
            5'd5:  r.v = vs ^ b;
            5'd6:  r.v = vs / (32'd1 << sh);
            5'd7:  r.v = (vs / (32'd1 << sh)) | ((sv < 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            5'd8:  r.v = vs | b;
            5'd9:  r.v = vs & b;
            5'd10: r.v = imm;
            5'd11: r.v = pc + imm;
            5'd12: r = '{nxt, 1'b1, 1'b1, pc + imm};
            5'd13: r = '{nxt, 1'b1, 1'b1, (vs + imm) & 32'hFFFF_FFFE};
            5'd14: r.taken = vs == vt;
            5'd15: r.taken = vs != vt;
            5'd16: r.taken = sv < st;
            5'd17: r.taken = sv >= st;
            5'd18: r.taken = vs < vt;
            5'd19: r.taken = vs >= vt;
            default: ;
        endcase
        if (op[4:0] >= 5'd14 && op[4:0] <= 5'd19) begin
            r.br = 1'b1;
            r.tgt = r.taken ? pc + imm : nxt;
        end
        return r;
    endfunction

    task automatic add(logic [5:0] op, logic ic, logic [31:0] vs, vt, imm, pc, v,
                       logic br, tk, logic [31:0] tgt);
        tab.push_back('{op, ic, vs, vt, imm, pc, '{v, br, tk, tgt}});
    endtask

    task automatic drive(logic [5:0] op, logic ic, logic [3:0] qd, logic [31:0] vs, vt, imm, pc, res_t r);
        bus.alu_en_i = 1'b1;
        bus.alu_op_i = op;
        bus.alu_ic_i = ic;
        bus.alu_qd_i = qd;
        bus.alu_vs_i = vs;
        bus.alu_vt_i = vt;
        bus.alu_imm_i = imm;
        bus.alu_pc_i = pc;
        cur_exp = r;
    endtask

    task automatic drive_rand(logic [3:0] qd);
        logic [5:0] op;
        logic [31:0] vs, vt, imm, pc;
        logic ic;
        op = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 21))};
        ic = 1'($urandom_range(0, 1));
        vs = $urandom;
        vt = ($urandom_range(0, 3) == 0) ? vs : $urandom;
        imm = $urandom;
        pc = $urandom & 32'hFFFF_FFFE;
        drive(op, ic, qd, vs, vt, imm, pc, model(op, ic, vs, vt, imm, pc));
    endtask

    // One clock: compare at the falling edge, advance the model, resume 1 time unit past the rising edge.
    task automatic tick();
        logic exp_en, exp_rdy;
        @(negedge clk);
        exp_rdy = sbq.size() < 4;
        exp_en = sbq.size() > 0 && sbq[0].t_vis <= cyc;
        chk1("rdy", bus.alu_rdy_o, exp_rdy);
        chk1("cdb_en", bus.cdb_en_o, exp_en);
        chk1("ovf", bus.ovf_o, exp_ovf);
        if (exp_en) begin
            chk("cdb_q", 32'(bus.cdb_q_o), 32'(sbq[0].q));
            chk("cdb_v", bus.cdb_v_o, sbq[0].r.v);
            chk1("cdb_br", bus.cdb_br_o, sbq[0].r.br);
            chk1("cdb_taken", bus.cdb_taken_o, sbq[0].r.taken);
            chk("cdb_tgt", bus.cdb_tgt_o, sbq[0].r.tgt);
        end
        exp_ovf = bus.alu_en_i & ~exp_rdy;
        if (bus.br_flag) sbq.delete();
        else begin
            if (exp_en && bus.cdb_gnt_i) void'(sbq.pop_front());
            if (bus.alu_en_i && exp_rdy) sbq.push_back('{bus.alu_qd_i, cur_exp, cyc + 2});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        bus.alu_en_i = 1'b0;
        bus.alu_op_i = '0;
        bus.alu_ic_i = 1'b0;
        bus.alu_qd_i = '0;
        bus.alu_vs_i = '0;
        bus.alu_vt_i = '0;
        bus.alu_imm_i = '0;
        bus.alu_pc_i = '0;
        bus.cdb_gnt_i = 1'b0;
        bus.br_flag = 1'b0;
        cur_exp = '{32'd0, 1'b0, 1'b0, 32'd0};
        add(6'h00, 1'b0, 32'd5, 32'd7, 32'd0, 32'h0, 32'd12, 1'b0, 1'b0, 32'h4);
        add(6'h27, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h8, 32'hF800_0000, 1'b0, 1'b0, 32'hC);
        add(6'h04, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'd1, 1'b0, 1'b0, 32'h4);
        add(6'h0F, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 32'd0, 1'b1, 1'b1, 32'h120);
        add(6'h0F, 1'b1, 32'd5, 32'd5, 32'h20, 32'h100, 32'd0, 1'b1, 1'b0, 32'h102);
        add(6'h0D, 1'b0, 32'h201, 32'd0, 32'd0, 32'h40, 32'h44, 1'b1, 1'b1, 32'h200);
        add(6'h0C, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h1000, 32'h1002, 1'b1, 1'b1, 32'hFF0);
        add(6'h0A, 1'b0, 32'd9, 32'd9, 32'h1234_5000, 32'h0, 32'h1234_5000, 1'b0, 1'b0, 32'h4);
        add(6'h0B, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h10, 32'h1010, 1'b0, 1'b0, 32'h14);
        add(6'h01, 1'b0, 32'd3, 32'd5, 32'd0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h4);
        add(6'h10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h200, 32'd0, 1'b1, 1'b1, 32'h208);
        add(6'h12, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h200, 32'd0, 1'b1, 1'b0, 32'h204);
        add(6'h11, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd8, 32'h200, 32'd0, 1'b1, 1'b1, 32'h208);
        add(6'h13, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd8, 32'h200, 32'd0, 1'b1, 1'b0, 32'h204);
        add(6'h0E, 1'b1, 32'd7, 32'd7, 32'h40, 32'h300, 32'd0, 1'b1, 1'b1, 32'h340);
        add(6'h19, 1'b0, 32'd7, 32'd3, 32'd1, 32'h300, 32'd0, 1'b0, 1'b0, 32'h304);
        add(6'h23, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'h0, 32'd1, 1'b0, 1'b0, 32'h4);
        add(6'h05, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0, 32'h0000_0FF0, 1'b0, 1'b0, 32'h4);
        add(6'h08, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0, 32'h0000_FFF0, 1'b0, 1'b0, 32'h4);
        add(6'h09, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0, 32'h0000_F000, 1'b0, 1'b0, 32'h4);
        add(6'h02, 1'b0, 32'd1, 32'd31, 32'd0, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 32'h4);
        add(6'h06, 1'b0, 32'h8000_0000, 32'h24, 32'd0, 32'h0, 32'h0800_0000, 1'b0, 1'b0, 32'h4);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("reset rdy", bus.alu_rdy_o, 1'b1);
        chk1("reset cdb_en", bus.cdb_en_o, 1'b0);
        chk("reset cdb_v", bus.cdb_v_o, 32'd0);
        chk("reset cdb_tgt", bus.cdb_tgt_o, 32'd0);
        chk1("reset ovf", bus.ovf_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // table vectors, one issue per cycle with grant held high
        bus.cdb_gnt_i = 1'b1;
        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].op, tab[i].ic, 4'((i % 15) + 1), tab[i].vs, tab[i].vt, tab[i].imm, tab[i].pc, tab[i].r);
            tick();
            bus.alu_en_i = 1'b0;
            if (i % 4 == 0) repeat (3) tick();
        end
        repeat (4) tick();

        // fill with no grant, overflow, then drain in order
        bus.cdb_gnt_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_rand(4'(i + 1));
            tick();
        end
        bus.alu_en_i = 1'b0;
        repeat (2) tick();
        bus.cdb_gnt_i = 1'b1;
        repeat (6) tick();

        // flush with three queued, one in S1 and a same-cycle issue
        bus.cdb_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand(4'(i + 5));
            tick();
        end
        bus.br_flag = 1'b1;
        drive_rand(4'd9);
        tick();
        bus.br_flag = 1'b0;
        bus.alu_en_i = 1'b0;
        repeat (3) tick();

        // asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) begin
            drive_rand(4'(i + 10));
            tick();
        end
        bus.alu_en_i = 1'b0;
        bus.cdb_gnt_i = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk1("async rst cdb_en", bus.cdb_en_o, 1'b0);
        chk("async rst cdb_v", bus.cdb_v_o, 32'd0);
        chk("async rst cdb_q", 32'(bus.cdb_q_o), 32'd0);
        chk1("async rst rdy", bus.alu_rdy_o, 1'b1);
        sbq.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        drive(6'h00, 1'b0, 4'd3, 32'd5, 32'd7, 32'd0, 32'h0, model(6'h00, 1'b0, 32'd5, 32'd7, 32'd0, 32'h0));
        tick();
        bus.alu_en_i = 1'b0;
        repeat (4) tick();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 7) drive_rand(4'($urandom_range(1, 15)));
            else bus.alu_en_i = 1'b0;
            bus.cdb_gnt_i = ($urandom_range(0, 9) < 6);
            bus.br_flag = ($urandom_range(0, 49) == 0);
            tick();
        end
        bus.alu_en_i = 1'b0;
        bus.br_flag = 1'b0;
        bus.cdb_gnt_i = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
